// File: rtl/seq_reset_cond_bus_gen.sv
// Two-stage reset-condition bus producer with req/ack handshake and a capture register
// cleared by the reduced bus. Define SEQ_RESET_COND_BUS_GEN_STATUS_EN to add the seq_count output.
module seq_reset_cond_bus_gen #(
   parameter int unsigned HOLD0 = 4,
   parameter int unsigned HOLD1 = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   output logic       ack,
   output logic       busy,
   output logic [1:0] rst_out,
   input  logic [7:0] d,
   output logic [7:0] q
`ifdef SEQ_RESET_COND_BUS_GEN_STATUS_EN
   ,
   output logic [7:0] seq_count
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      REL0   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] HOLD0_LAST = CNT_W'(HOLD0 - 1);
   localparam logic [CNT_W-1:0] HOLD1_LAST = CNT_W'(HOLD1 - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [1:0]       rst_out_r;
   logic [1:0]       rst_out_nxt_s;
   logic             ack_r;
   logic             ack_nxt_s;
   logic             busy_r;
   logic             busy_nxt_s;
   logic [7:0]       q_r;

   // Next-state and hold counter; counter only runs up to HOLDx-1 so it never wraps
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (req) begin
               state_nxt_s = ASSERT;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ASSERT: begin
            if (cnt_r == HOLD0_LAST) begin
               state_nxt_s = REL0;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         REL0: begin
            if (cnt_r == HOLD1_LAST) begin
               state_nxt_s = DONE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output values decoded from the next state so they register together with it
   always_comb begin
      rst_out_nxt_s = 2'b00;
      ack_nxt_s     = 1'b0;
      busy_nxt_s    = 1'b1;
      case (state_nxt_s)
         IDLE:    busy_nxt_s    = 1'b0;
         ASSERT:  rst_out_nxt_s = 2'b11;
         REL0:    rst_out_nxt_s = 2'b10;
         DONE:    ack_nxt_s     = 1'b1;
         default: busy_nxt_s    = 1'b0;
      endcase
   end

   // Sequencer state and registered outputs; rst restarts the full hold sequence
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ASSERT;
         cnt_r     <= {CNT_W{1'b0}};
         rst_out_r <= 2'b11;
         ack_r     <= 1'b0;
         busy_r    <= 1'b1;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         rst_out_r <= rst_out_nxt_s;
         ack_r     <= ack_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

   // Capture register cleared by the 1-bit reduction of the registered bus
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= 8'h00;
      end else if (|rst_out_r) begin
         q_r <= 8'h00;
      end else begin
         q_r <= d;
      end
   end

`ifdef SEQ_RESET_COND_BUS_GEN_STATUS_EN
   logic [7:0] seq_count_r;

   // Completed-sequence counter, steps on the same edge that raises ack
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_count_r <= 8'h00;
      end else if (ack_nxt_s) begin
         seq_count_r <= seq_count_r + 8'h01;
      end else begin
         seq_count_r <= seq_count_r;
      end
   end

   assign seq_count = seq_count_r;
`endif

   assign rst_out = rst_out_r;
   assign ack     = ack_r;
   assign busy    = busy_r;
   assign q       = q_r;

endmodule
